adc_capture_multi: RTL and testbench

// - Parametrised multi-channel capture front end for AD9226-class pipelined ADCs.
// - Generates the shared ADC sample clock, captures CH parallel buses and discards pipeline-latency samples after start.
// - Optionally box-car averages 2^AVG_LOG2 samples and presents offset-binary or two's-complement words.
// - Sits between the ADC pins and the DSP/FIFO chain. Replaces the fixed div-4, single-channel, always-on driver.

---
 rtl/adc_cap_pkg.sv | 23 ++
 rtl/adc_capture_multi_clk_gen.sv | 44 ++++
 rtl/adc_capture_multi.sv | 180 ++++++++++++++++++
 tb/tb_adc_capture_multi.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_cap_pkg.sv
// Shared types and helpers for the multi-channel ADC capture front end.
package adc_cap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Accumulator width: DATA_W plus headroom for 2^AVG_LOG2 addends.
    function automatic int acc_w(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

endpackage

// File: rtl/adc_capture_multi_clk_gen.sv
// ADC sample clock divider: free-running count while active, registered
// 50% clock, capture strobe at SAMPLE_PH and end-of-period flag.
module adc_clk_gen
    import adc_cap_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int SAMPLE_PH = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic adc_clk_o,
    output logic cap_o,
    output logic eop_o
);

    localparam int CNT_W = clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             adc_clk_q;

    // Count wraps each ADC period; held at 0 while idle so a start is phase-aligned.
    always_comb begin
        cnt_d = '0;
        if (run_i)
            cnt_d = (cnt_q == CNT_W'(CLK_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
    end

    // Clock is decoded from the next count so it lines up with cnt_q without glitches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            adc_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            adc_clk_q <= (cnt_d >= CNT_W'(CLK_DIV / 2));
        end
    end

    assign adc_clk_o = adc_clk_q;
    assign cap_o     = run_i && (cnt_q == CNT_W'(SAMPLE_PH));
    assign eop_o     = run_i && (cnt_q == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/adc_capture_multi.sv
// Multi-channel ADC capture: start/flush/run sequencing, per-channel
// box-car averaging with optional two's-complement output, sticky OTR.
module adc_capture_multi
    import adc_cap_pkg::*;
#(
    parameter int CH        = 2,
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 4,
    parameter int SAMPLE_PH = 1,
    parameter int PIPE_LAT  = 7,
    parameter int AVG_LOG2  = 0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 i_enable,
    input  logic                 i_fmt_twos,
    input  logic                 i_otr_clr,
    output logic                 o_adc_clk,
    input  logic [CH*DATA_W-1:0] i_adc_data,
    input  logic [CH-1:0]        i_adc_otr,
    output logic [CH*DATA_W-1:0] o_data,
    output logic [CH-1:0]        o_otr,
    output logic                 o_valid,
    output logic [CH-1:0]        o_otr_sticky,
    output logic                 o_busy
);

    localparam int ACC_W = acc_w(DATA_W, AVG_LOG2);
    localparam int BLK_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int FL_W  = (clog2(PIPE_LAT + 1) > 0) ? clog2(PIPE_LAT + 1) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'((1 << AVG_LOG2) - 1);

    state_e                state_q, state_d;
    logic [FL_W-1:0]       flush_q, flush_d;
    logic                  stop_q, stop_d;
    logic                  fmt_q, fmt_d;
    logic                  cap, eop, stopping, cap_ok, run_cap;
    logic                  take_q, blk_last;
    logic [BLK_W-1:0]      blk_q;
    logic [CH*DATA_W-1:0]  smp_q, data_d, data_q;
    logic [CH-1:0]         otr_smp_q, otr_d, otr_q, sticky_q;
    logic                  valid_q;

    adc_clk_gen #(
        .CLK_DIV  (CLK_DIV),
        .SAMPLE_PH(SAMPLE_PH)
    ) u_clk_gen (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .run_i    (state_q != IDLE),
        .adc_clk_o(o_adc_clk),
        .cap_o    (cap),
        .eop_o    (eop)
    );

    // Once enable drops, the stop is latched so a re-assert cannot cancel it.
    assign stopping = !i_enable || stop_q;
    assign cap_ok   = cap && !stopping;
    assign run_cap  = cap_ok && (state_q == RUN);
    assign blk_last = (blk_q == BLK_LAST);

    // Next-state: start from IDLE, count flushed samples, wind down at period end.
    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        stop_d  = stop_q;
        fmt_d   = fmt_q;
        case (state_q)
            IDLE: begin
                stop_d = 1'b0;
                if (i_enable) begin
                    fmt_d   = i_fmt_twos;
                    flush_d = '0;
                    state_d = (PIPE_LAT == 0) ? RUN : FLUSH;
                end
            end
            FLUSH, RUN: begin
                if (!i_enable) stop_d = 1'b1;
                if (stopping && eop) begin
                    state_d = IDLE;
                end else if (state_q == FLUSH && cap_ok) begin
                    flush_d = flush_q + FL_W'(1);
                    if (flush_d == FL_W'(PIPE_LAT)) state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            flush_q <= '0;
            stop_q  <= 1'b0;
            fmt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            stop_q  <= stop_d;
            fmt_q   <= fmt_d;
        end
    end

    // Input capture on the strobe; take_q marks a sample accepted into a block.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            smp_q     <= '0;
            otr_smp_q <= '0;
            take_q    <= 1'b0;
        end else begin
            take_q <= run_cap;
            if (cap) begin
                smp_q     <= i_adc_data;
                otr_smp_q <= i_adc_otr;
            end
        end
    end

    // Block position, shared by all channels; cleared in IDLE to drop partial blocks.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)               blk_q <= '0;
        else if (state_q == IDLE)  blk_q <= '0;
        else if (take_q)           blk_q <= blk_last ? '0 : blk_q + BLK_W'(1);
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [ACC_W-1:0]  acc_q, sum;
        logic [DATA_W-1:0] avg;
        logic              otr_acc_q;

        assign sum = acc_q + ACC_W'(smp_q[k*DATA_W +: DATA_W]);
        assign avg = DATA_W'(sum >> AVG_LOG2);
        // Offset binary to two's complement is an MSB flip.
        assign data_d[k*DATA_W +: DATA_W] = {avg[DATA_W-1] ^ fmt_q, avg[DATA_W-2:0]};
        assign otr_d[k] = otr_acc_q | otr_smp_q[k];

        // Per-channel running sum and OTR OR, reloaded at each block boundary.
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                acc_q     <= '0;
                otr_acc_q <= 1'b0;
            end else if (state_q == IDLE) begin
                acc_q     <= '0;
                otr_acc_q <= 1'b0;
            end else if (take_q) begin
                acc_q     <= blk_last ? '0 : sum;
                otr_acc_q <= blk_last ? 1'b0 : otr_d[k];
            end
        end
    end

    // Output words update one cycle after the block's last sample is taken.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            data_q  <= '0;
            otr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= take_q && blk_last;
            if (take_q && blk_last) begin
                data_q <= data_d;
                otr_q  <= otr_d;
            end
        end
    end

    // Sticky OTR: a set in the same cycle as a clear wins.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) sticky_q <= '0;
        else         sticky_q <= (sticky_q & ~{CH{i_otr_clr}}) | (run_cap ? i_adc_otr : '0);
    end

    assign o_data       = data_q;
    assign o_otr        = otr_q;
    assign o_valid      = valid_q;
    assign o_otr_sticky = sticky_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adc_capture_multi.sv
// Scoreboard bench: two instances (pass-through and 4-sample average) share
// stimulus; expected words are computed per ADC period and checked by a monitor.
module tb_adc_capture_multi;

    localparam int CH = 2, DW = 12, CD = 4, SP = 1, PL = 7;

    logic sys_clk = 1'b0, sys_rst = 1'b1;
    logic i_enable = 1'b0, i_fmt_twos = 1'b0, i_otr_clr = 1'b0;
    logic [CH*DW-1:0] i_adc_data = '0;
    logic [CH-1:0]    i_adc_otr  = '0;

    logic clk0, valid0, busy0, clk2, valid2, busy2;
    logic [CH*DW-1:0] data0, data2;
    logic [CH-1:0]    otr0, otr2, sticky0, sticky2;

    adc_capture_multi #(.CH(CH), .DATA_W(DW), .CLK_DIV(CD), .SAMPLE_PH(SP),
                        .PIPE_LAT(PL), .AVG_LOG2(0)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .i_enable(i_enable),
        .i_fmt_twos(i_fmt_twos), .i_otr_clr(i_otr_clr), .o_adc_clk(clk0),
        .i_adc_data(i_adc_data), .i_adc_otr(i_adc_otr), .o_data(data0),
        .o_otr(otr0), .o_valid(valid0), .o_otr_sticky(sticky0), .o_busy(busy0));

    adc_capture_multi #(.CH(CH), .DATA_W(DW), .CLK_DIV(CD), .SAMPLE_PH(SP),
                        .PIPE_LAT(PL), .AVG_LOG2(2)) u_avg (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .i_enable(i_enable),
        .i_fmt_twos(i_fmt_twos), .i_otr_clr(i_otr_clr), .o_adc_clk(clk2),
        .i_adc_data(i_adc_data), .i_adc_otr(i_adc_otr), .o_data(data2),
        .o_otr(otr2), .o_valid(valid2), .o_otr_sticky(sticky2), .o_busy(busy2));

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [CH*DW-1:0] data;
        logic [CH-1:0]    otr;
        int               at;
    } exp_t;

    exp_t q0[$], q2[$];
    int checks = 0, errors = 0;
    int e0 = 0, eend = 0;
    bit chk_on = 1'b0;
    logic [CH-1:0] sticky_m = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: ADC clock/busy shape each cycle, and scoreboard pops on o_valid.
    always @(negedge sys_clk) begin
        bit act, ck;
        exp_t e;
        if (chk_on) begin
            act = (cyc >= e0) && (cyc < eend);
            ck  = act && (((cyc - e0) % CD) >= CD / 2);
            chk("adc_clk0", 32'(clk0), 32'(ck));
            chk("adc_clk2", 32'(clk2), 32'(ck));
            chk("busy0", 32'(busy0), 32'(act));
            chk("busy2", 32'(busy2), 32'(act));
            if (valid0) begin
                if (q0.size() == 0) chk("unexpected_valid0", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    chk("data0", 32'(data0), 32'(e.data));
                    chk("otr0", 32'(otr0), 32'(e.otr));
                    chk("valid_cycle0", 32'(cyc), 32'(e.at));
                end
            end
            if (valid2) begin
                if (q2.size() == 0) chk("unexpected_valid2", 32'd1, 32'd0);
                else begin
                    e = q2.pop_front();
                    chk("data2", 32'(data2), 32'(e.data));
                    chk("otr2", 32'(otr2), 32'(e.otr));
                    chk("valid_cycle2", 32'(cyc), 32'(e.at));
                end
            end
        end
    end

    // mode 1: ramp on ch0, 0x800.. block on ch1, directed OTR/clear.
    // mode 2: half-scale block on ch1, full-scale extremes on ch0.
    task automatic session(input int nper, input bit fmt, input int rst_at, input int mode);
        logic [CH*DW-1:0] dat[];
        logic [CH-1:0]    otr[];
        bit               clr[];
        logic [DW-1:0]    avg;
        exp_t             e;
        int               nacc, n, sum;
        bit               run;
        dat = new[nper]; otr = new[nper]; clr = new[nper];
        for (int k = 0; k < nper; k++) begin
            dat[k] = CH*DW'({$urandom, $urandom});
            otr[k] = (mode == 1) ? '0 : (($urandom_range(7) == 0) ? CH'($urandom) : '0);
            clr[k] = (mode == 1) ? 1'b0 : ($urandom_range(5) == 0);
            if (mode == 1 && k >= PL) dat[k][DW-1:0] = DW'(k - PL);
            if (mode != 0 && k >= PL && k < PL + 4) dat[k][DW +: DW] = DW'(12'h800 + k - PL);
        end
        if (mode == 1) begin
            otr[PL+5] = 2'b01;                  // one OTR inside the second 4-block
            clr[PL+7] = 1'b1;                   // clear with no OTR present
            otr[PL+9] = 2'b01; clr[PL+9] = 1'b1; // clear coinciding with a new OTR
        end
        if (mode == 2) begin
            dat[PL][DW-1:0]   = 12'h000;
            dat[PL+1][DW-1:0] = 12'hFFF;
        end
        if (rst_at > 0) begin
            dat[rst_at-1][0] = 1'b1;
            dat[rst_at][0]   = 1'b1;
        end
        nacc = (rst_at >= 0) ? rst_at : nper;

        @(posedge sys_clk); #1;
        e0   = cyc + 1;
        eend = e0 + CD * (nper + 1);
        // Expected blocks: discard PL periods, average groups of 2^a, shift to two's complement.
        for (int a = 0; a <= 2; a += 2) begin
            n = 1 << a;
            for (int b = 0; PL + (b + 1) * n <= nacc; b++) begin
                e.data = '0; e.otr = '0;
                for (int c = 0; c < CH; c++) begin
                    sum = 0;
                    for (int j = 0; j < n; j++) begin
                        sum += int'(dat[PL + b*n + j][c*DW +: DW]);
                        e.otr[c] = e.otr[c] | otr[PL + b*n + j][c];
                    end
                    avg = DW'(sum / n);
                    if (fmt) avg = avg - 12'h800;
                    e.data[c*DW +: DW] = avg;
                end
                e.at = e0 + CD * (PL + (b + 1) * n - 1) + SP + 2;
                if (a == 0) q0.push_back(e); else q2.push_back(e);
            end
        end
        for (int k = 0; k < nacc; k++) begin
            run = (k >= PL);
            if (clr[k]) sticky_m = run ? otr[k] : '0;
            else if (run) sticky_m = sticky_m | otr[k];
        end

        i_enable = 1'b1; i_fmt_twos = fmt;
        @(posedge sys_clk); #1;
        for (int k = 0; k < nper; k++) begin
            i_adc_data = dat[k]; i_adc_otr = otr[k];
            @(posedge sys_clk); #1;
            i_otr_clr = clr[k];
            @(posedge sys_clk); #1;
            i_otr_clr = 1'b0;
            if (k == rst_at) begin
                chk("clk_high_at_rst", 32'(clk0), 32'd1);
                chk("q0_empty_before_rst", 32'(q0.size()), 32'd0);
                chk("q2_empty_before_rst", 32'(q2.size()), 32'd0);
                chk_on = 1'b0;
                sys_rst = 1'b1;
                #1;
                chk("rst_outputs0", 32'({clk0, data0, otr0, valid0, sticky0, busy0}), 32'd0);
                chk("rst_outputs2", 32'({clk2, data2, otr2, valid2, sticky2, busy2}), 32'd0);
                i_enable = 1'b0; i_adc_otr = '0;
                q0.delete(); q2.delete(); sticky_m = '0;
                e0 = 0; eend = 0;
                repeat (3) @(posedge sys_clk);
                #1;
                sys_rst = 1'b0;
                chk_on = 1'b1;
                return;
            end
            @(posedge sys_clk); #1;
            @(posedge sys_clk); #1;
        end
        // Drop enable at the start of a period; its capture (with OTR set) must be ignored.
        i_enable = 1'b0;
        i_adc_data = CH*DW'({$urandom, $urandom});
        i_adc_otr = '1;
        repeat (CD + 3) @(posedge sys_clk);
        #1;
        i_adc_otr = '0;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        chk("sticky0", 32'(sticky0), 32'(sticky_m));
        chk("sticky2", 32'(sticky2), 32'(sticky_m));
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_outputs0", 32'({clk0, data0, otr0, valid0, sticky0, busy0}), 32'd0);
        chk("reset_outputs2", 32'({clk2, data2, otr2, valid2, sticky2, busy2}), 32'd0);
        sys_rst = 1'b0;
        chk_on = 1'b1;
        repeat (2) @(posedge sys_clk);
        session(PL + 12, 1'b0, -1, 1);       // ramp, 0x800 block, OTR and clear cases
        session(PL + 10, 1'b0, -1, 0);       // enable dropped mid-block
        session(PL + 8,  1'b1, -1, 2);       // two's complement extremes
        session(PL + 12, 1'b0, PL + 5, 0);   // reset while clock high and acc non-zero
        session(PL + 12, 1'b0, -1, 1);       // first-power-up behaviour again
        for (int r = 0; r < 3; r++)
            session(PL + int'($urandom_range(1, 12)), 1'($urandom_range(1)), -1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
